// File: rtl/fft_frame_driver_if.sv
// Bundle of the sample stream, core frame bus and result stream around fft_frame_driver.
// The master modport is the driver's view; slave is the surrounding fabric/core view.
`timescale 1ns/1ps
interface fft_frame_driver_if #(
    parameter int unsigned N  = 8,
    parameter int unsigned CW = 32
);
    logic                  s_valid;
    logic                  s_ready;
    logic [2*CW-1:0]       s_data;
    logic [N*2*CW-1:0]     fft_in;
    logic                  fft_next;
    logic [N*2*CW-1:0]     fft_out;
    logic                  fft_next_out;
    logic                  m_valid;
    logic                  m_ready;
    logic [2*CW-1:0]       m_data;
    logic                  m_last;
    logic                  busy;
    logic                  err_spurious;

    modport master (
        input  s_valid, s_data, fft_out, fft_next_out, m_ready,
        output s_ready, fft_in, fft_next, m_valid, m_data, m_last, busy, err_spurious
    );

    modport slave (
        output s_valid, s_data, fft_out, fft_next_out, m_ready,
        input  s_ready, fft_in, fft_next, m_valid, m_data, m_last, busy, err_spurious
    );
endinterface

// File: rtl/fft_frame_driver.sv
// Collects N serial complex samples into a frame for a parallel FFT core, pulses the core,
// captures its result vector and streams it back out with a frame-end marker.
`timescale 1ns/1ps
module fft_frame_driver #(
    parameter int unsigned N  = 8,
    parameter int unsigned CW = 32
) (
    input logic                clk,
    input logic                reset,
    fft_frame_driver_if.master bus
);
    localparam int unsigned W  = 2 * CW;
    localparam int unsigned IW = $clog2(N);

    typedef enum logic [1:0] {StFill, StIssue, StWait, StDrain} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   count_q, count_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [W-1:0]    slot_q   [N];
    logic [W-1:0]    result_q [N];
    logic            err_q;

    logic            s_ready;
    logic            fft_next;
    logic            m_valid;
    logic            m_last;
    logic            capture;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        idx_d    = idx_q;
        s_ready  = 1'b0;
        fft_next = 1'b0;
        m_valid  = 1'b0;
        m_last   = 1'b0;
        capture  = 1'b0;
        unique case (state_q)
            StFill: begin
                s_ready = 1'b1;
                if (bus.s_valid) begin
                    if (count_q == IW'(N - 1)) begin
                        count_d = '0;
                        state_d = StIssue;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            StIssue: begin
                fft_next = 1'b1;
                state_d  = StWait;
            end
            StWait: begin
                if (bus.fft_next_out) begin
                    capture = 1'b1;
                    idx_d   = '0;
                    state_d = StDrain;
                end
            end
            StDrain: begin
                m_valid = 1'b1;
                m_last  = (idx_q == IW'(N - 1));
                if (bus.m_ready) begin
                    if (m_last) begin
                        idx_d   = '0;
                        count_d = '0;
                        state_d = StFill;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = StFill;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFill;
            count_q <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            for (int k = 0; k < N; k++) begin
                slot_q[k]   <= '0;
                result_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            if (s_ready && bus.s_valid) begin
                slot_q[count_q] <= bus.s_data;
            end
            if (capture) begin
                for (int k = 0; k < N; k++) begin
                    result_q[k] <= bus.fft_out[k*W +: W];
                end
            end
            // A result pulse outside WAIT is flagged and otherwise dropped.
            if (bus.fft_next_out && (state_q != StWait)) begin
                err_q <= 1'b1;
            end
        end
    end

    // Slots only change in FILL, so the frame stays stable while the core works on it.
    for (genvar k = 0; k < N; k++) begin : g_pack
        assign bus.fft_in[k*W +: W] = slot_q[k];
    end

    assign bus.s_ready      = s_ready;
    assign bus.fft_next     = fft_next;
    assign bus.m_valid      = m_valid;
    assign bus.m_last       = m_last;
    assign bus.m_data       = m_valid ? result_q[idx_q] : '0;
    assign bus.busy         = !((state_q == StFill) && (count_q == '0));
    assign bus.err_spurious = err_q;
endmodule

// File: tb/tb_fft_frame_driver.sv
// Directed bench for fft_frame_driver: an N=8 instance with a fixed-pattern core model and
// an N=16 instance whose core model returns the input frame reversed.
`timescale 1ns/1ps
module tb_fft_frame_driver;
    localparam int unsigned CW = 32;
    localparam int unsigned W  = 2 * CW;

    logic clk = 1'b0;
    logic rst8;
    logic rst16;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    fft_frame_driver_if #(.N(8),  .CW(CW)) if8 ();
    fft_frame_driver_if #(.N(16), .CW(CW)) if16 ();

    fft_frame_driver #(.N(8),  .CW(CW)) dut8  (.clk(clk), .reset(rst8),  .bus(if8));
    fft_frame_driver #(.N(16), .CW(CW)) dut16 (.clk(clk), .reset(rst16), .bus(if16));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // N=8 core: result k = {2k, ~k}, pulse 5 cycles after fft_next.
    logic           core8_pulse = 1'b0;
    logic           spur8 = 1'b0;
    int             lat8 = 0;
    logic [8*W-1:0] out8;
    always_comb begin
        out8 = '0;
        for (int k = 0; k < 8; k++) out8[k*W +: W] = {32'(2 * k), ~32'(k)};
    end
    assign if8.fft_out      = out8;
    assign if8.fft_next_out = core8_pulse | spur8;
    always @(posedge clk) begin
        core8_pulse <= 1'b0;
        if (rst8) lat8 <= 0;
        else if (if8.fft_next) lat8 <= 4;
        else if (lat8 > 0) begin
            lat8 <= lat8 - 1;
            if (lat8 == 1) core8_pulse <= 1'b1;
        end
    end

    // N=16 core: result k = input element 15-k, pulse 3 cycles after fft_next.
    logic            core16_pulse = 1'b0;
    int              lat16 = 0;
    logic [16*W-1:0] out16;
    int              nx16_t[$];
    always_comb begin
        out16 = '0;
        for (int k = 0; k < 16; k++) out16[k*W +: W] = if16.fft_in[(15 - k)*W +: W];
    end
    assign if16.fft_out      = out16;
    assign if16.fft_next_out = core16_pulse;
    always @(posedge clk) begin
        core16_pulse <= 1'b0;
        if (rst16) lat16 <= 0;
        else if (if16.fft_next) begin
            lat16 <= 2;
            nx16_t.push_back(cyc);
        end else if (lat16 > 0) begin
            lat16 <= lat16 - 1;
            if (lat16 == 1) core16_pulse <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put8(input logic [63:0] d);
        int n;
        n = 0;
        if8.s_valid = 1'b1;
        if8.s_data  = d;
        while (!if8.s_ready && n < 100) begin
            step();
            n++;
        end
        check("put8_ready", if8.s_ready, 1'b1);
        step();
        if8.s_valid = 1'b0;
    endtask

    task automatic put8_range(input int lo, input int hi, input int rb, input int ib);
        for (int k = lo; k <= hi; k++) put8({32'(rb + k), 32'(ib + k)});
    endtask

    task automatic wait_mvalid8(input int start, output int n);
        n = start;
        while (!if8.m_valid && n < 100) begin
            step();
            n++;
        end
        check("m_valid_wait", if8.m_valid, 1'b1);
    endtask

    // mode 0: m_ready always high; mode 1: m_ready pattern 1,0,0 repeating.
    task automatic drain8(input int mode);
        int beat;
        int n;
        beat = 0;
        n = 0;
        while (beat < 8 && n < 200) begin
            if8.m_ready = (mode == 0) || (n % 3 == 0);
            check("m_valid", if8.m_valid, 1'b1);
            check("m_data", if8.m_data, {32'(2 * beat), ~32'(beat)});
            check("m_last", if8.m_last, beat == 7);
            if (if8.m_ready) beat++;
            step();
            n++;
        end
        if8.m_ready = 1'b0;
        check("beats8", beat, 8);
        check("s_ready_after", if8.s_ready, 1'b1);
        check("m_valid_after", if8.m_valid, 1'b0);
        check("busy_after", if8.busy, 1'b0);
    endtask

    task automatic check_reset8();
        check("rst_s_ready", if8.s_ready, 1'b1);
        check("rst_fft_next", if8.fft_next, 1'b0);
        check("rst_fft_in", if8.fft_in == '0, 1'b1);
        check("rst_m_valid", if8.m_valid, 1'b0);
        check("rst_m_data", if8.m_data, 64'd0);
        check("rst_m_last", if8.m_last, 1'b0);
        check("rst_busy", if8.busy, 1'b0);
        check("rst_err", if8.err_spurious, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst8 = 1'b1;
        rst16 = 1'b1;
        if8.s_valid = 1'b0;
        if8.s_data = '0;
        if8.m_ready = 1'b0;
        if16.s_valid = 1'b0;
        if16.s_data = '0;
        if16.m_ready = 1'b0;
        repeat (3) step();
        check_reset8();
        rst8 = 1'b0;
        rst16 = 1'b0;
        step();

        // Fill a frame with continuous valid, then check issue timing and packing.
        put8_range(0, 7, 0, 100);
        check("issue_s_ready", if8.s_ready, 1'b0);
        check("issue_next", if8.fft_next, 1'b1);
        check("issue_el3", if8.fft_in[3*W +: W], {32'd3, 32'd103});
        check("issue_el7", if8.fft_in[7*W +: W], {32'd7, 32'd107});
        step();
        check("next_one_cycle", if8.fft_next, 1'b0);
        wait_mvalid8(1, n);
        check("result_latency", n, 6);
        drain8(0);

        // Spurious result pulse at count=3 during FILL.
        put8_range(0, 2, 20, 120);
        spur8 = 1'b1;
        step();
        spur8 = 1'b0;
        check("err_set", if8.err_spurious, 1'b1);
        check("busy_mid_fill", if8.busy, 1'b1);
        check("no_early_issue", if8.fft_next, 1'b0);
        put8_range(3, 7, 20, 120);
        check("spur_issue_next", if8.fft_next, 1'b1);
        check("spur_el3", if8.fft_in[3*W +: W], {32'd23, 32'd123});
        check("spur_el0", if8.fft_in[0 +: W], {32'd20, 32'd120});
        wait_mvalid8(0, n);
        drain8(1);
        check("err_sticky", if8.err_spurious, 1'b1);

        // Reset while the core is working, then a fresh frame.
        put8_range(0, 7, 50, 200);
        step();
        step();
        rst8 = 1'b1;
        step();
        rst8 = 1'b0;
        check_reset8();
        step();
        put8_range(0, 7, 10, 300);
        check("fresh_next", if8.fft_next, 1'b1);
        check("fresh_el0", if8.fft_in[0 +: W], {32'd10, 32'd300});
        check("fresh_el7", if8.fft_in[7*W +: W], {32'd17, 32'd307});
        wait_mvalid8(0, n);
        drain8(0);
        check("err_after_reset", if8.err_spurious, 1'b0);

        // N=16: two back-to-back frames with gapped input.
        fork
            begin : feed
                int g;
                int c;
                logic rdy;
                g = 0;
                c = 0;
                while (g < 32 && c < 2000) begin
                    if (c % 3 == 2) begin
                        if16.s_valid = 1'b0;
                        step();
                    end else begin
                        if16.s_valid = 1'b1;
                        if16.s_data = {32'(g), 32'(1000 + g)};
                        rdy = if16.s_ready;
                        step();
                        if (rdy) g++;
                    end
                    c++;
                end
                if16.s_valid = 1'b0;
                check("feed16_count", g, 32);
            end
            begin : sink
                int b;
                int c;
                int gexp;
                b = 0;
                c = 0;
                if16.m_ready = 1'b1;
                while (b < 32 && c < 3000) begin
                    if (if16.m_valid) begin
                        gexp = (b / 16) * 16 + 15 - (b % 16);
                        check("m16_data", if16.m_data, {32'(gexp), 32'(1000 + gexp)});
                        check("m16_last", if16.m_last, (b % 16) == 15);
                        b++;
                    end
                    step();
                    c++;
                end
                check("beats16", b, 32);
            end
        join
        check("next16_count", nx16_t.size(), 2);
        if (nx16_t.size() >= 2) check("next16_gap", (nx16_t[1] - nx16_t[0]) >= 37, 1'b1);
        check("err16", if16.err_spurious, 1'b0);
        check("idle16", if16.busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
